// File: rtl/ticket_pkg.sv
// Shared types and BCD helpers for the ticket-window countdown.
// Used by ticket_timer_ctrl and its testbench.
package ticket_pkg;

  typedef enum logic [1:0] {
    ST_SET  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam bcd2_t BCD_ONE = 8'h01;

  // +1 in BCD; the value max_tens*10 wraps to 00
  function automatic bcd2_t bcd_inc(
    input bcd2_t v,
    input bcd_t  max_tens
  );
    bcd2_t r;
    r = v;
    if (v.tens >= max_tens) begin
      r = '0;
    end else if (v.ones >= 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // -1 in BCD; 00 stays at 00
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd0) begin
      if (v.tens != 4'd0) begin
        r.tens = v.tens - 4'd1;
        r.ones = 4'd9;
      end
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key debouncer: one press pulse per qualified low period.
// Pulse is high in the cycle the low-run counter reaches DEBOUNCE_CYC.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] C_PRE = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_press;

  // saturating low-run counter; pulse registered alongside the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= !key_n && (r_cnt == C_PRE);
      if (key_n) begin
        r_cnt <= '0;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/ticket_timer_ctrl.sv
// Ticket-window countdown sequencer: preset entry, 1 Hz BCD countdown.
// Optional macro TICKET_AUTO_RELOAD_EN: reload preset on expiry, stay in RUN.
module ticket_timer_ctrl
  import ticket_pkg::*;
#(
  parameter int TICK_CYC     = 12_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int MAX_TENS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       sw,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] state,
  output logic       expired,
  output logic       busy
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
  localparam bcd_t MAXT = bcd_t'(MAX_TENS);

  state_e        r_state;
  bcd2_t         r_preset;
  bcd2_t         r_count;
  bcd2_t         r_disp;
  logic [PW-1:0] r_presc;
  logic          r_expired;

  state_e        w_state_n;
  bcd2_t         w_preset_n;
  bcd2_t         w_count_n;
  bcd2_t         w_disp_n;
  logic [PW-1:0] w_presc_n;
  logic          w_exp_n;
  logic          w_press;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(w_press)
  );

  // next-state logic for FSM, preset, count and prescaler
  always_comb begin
    w_state_n  = r_state;
    w_preset_n = r_preset;
    w_count_n  = r_count;
    w_presc_n  = r_presc;
    w_exp_n    = 1'b0;
    unique case (r_state)
      ST_SET: begin
        if (!sw) begin
          if (r_preset == '0) begin
            w_state_n = ST_DONE;
            w_exp_n   = 1'b1;
          end else begin
            w_state_n = ST_RUN;
            w_count_n = r_preset;
            w_presc_n = '0;
          end
        end else if (w_press) begin
          w_preset_n = bcd_inc(r_preset, MAXT);
        end
      end
      ST_RUN: begin
        if (sw) begin
          w_state_n = ST_SET;
        end else if (r_presc == TICK_LAST) begin
          w_presc_n = '0;
          if (r_count == BCD_ONE) begin
            w_exp_n = 1'b1;
`ifdef TICKET_AUTO_RELOAD_EN
            w_count_n = r_preset;
`else
            w_state_n = ST_DONE;
            w_count_n = '0;
`endif
          end else begin
            w_count_n = bcd_dec(r_count);
          end
        end else begin
          w_presc_n = r_presc + 1'b1;
        end
      end
      ST_DONE: begin
        if (sw) begin
          w_state_n = ST_SET;
        end
      end
      default: begin
        w_state_n = ST_SET;
      end
    endcase
  end

  // digits shown for the state being entered
  always_comb begin
    w_disp_n = '0;
    if (w_state_n == ST_SET) begin
      w_disp_n = w_preset_n;
    end else if (w_state_n == ST_RUN) begin
      w_disp_n = w_count_n;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_SET;
      r_preset  <= '0;
      r_count   <= '0;
      r_presc   <= '0;
      r_disp    <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_preset  <= w_preset_n;
      r_count   <= w_count_n;
      r_presc   <= w_presc_n;
      r_disp    <= w_disp_n;
      r_expired <= w_exp_n;
    end
  end

  assign tens    = r_disp.tens;
  assign ones    = r_disp.ones;
  assign state   = r_state;
  assign expired = r_expired;
  assign busy    = (r_state == ST_RUN);

endmodule

// File: tb/tb_ticket_timer_ctrl.sv
// Self-checking bench for ticket_timer_ctrl (TICK_CYC=10, DEBOUNCE_CYC=4).
// Honors TICKET_AUTO_RELOAD_EN when defined at compile time.
module tb_ticket_timer_ctrl;

  localparam int T = 10;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic       sw = 1'b1;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] state;
  logic       expired;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] st;
    logic       busy;
    logic       ex;
  } exp_t;

  typedef struct {
    bit   is_press;
    logic sw;
    int   edges;
    int   val;
    int   st;
    bit   ex;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  ticket_timer_ctrl #(
    .TICK_CYC    (T),
    .DEBOUNCE_CYC(D),
    .MAX_TENS    (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .key_n  (key_n),
    .sw     (sw),
    .tens   (tens),
    .ones   (ones),
    .state  (state),
    .expired(expired),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, int val, int st, bit ex);
    exp_t e;
    e.nm   = nm;
    e.tens = 4'(val / 10);
    e.ones = 4'(val % 10);
    e.st   = 2'(st);
    e.busy = (st == 1);
    e.ex   = ex;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (tens !== e.tens || ones !== e.ones || state !== e.st ||
        busy !== e.busy || expired !== e.ex) begin
      errors++;
      $display("FAIL %s @%0t: got %0d%0d st=%0d busy=%0b exp=%0b, want %0d%0d st=%0d busy=%0b exp=%0b",
               e.nm, $time, tens, ones, state, busy, expired,
               e.tens, e.ones, e.st, e.busy, e.ex);
    end
  endtask

  task automatic press();
    key_n = 1'b0;
    repeat (D) tick();
    key_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw    = 1'b1;
    key_n = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_preset(int n);
    for (int i = 0; i < n; i++) press();
  endtask

  // expected display/state j cycles after the first RUN cycle
  task automatic run_model(int n, int j, output int val,
                           output int st, output bit ex);
`ifdef TICKET_AUTO_RELOAD_EN
    st  = 1;
    ex  = (j > 0) && (j % (n * T) == 0);
    val = n - (j % (n * T)) / T;
`else
    if (j < n * T) begin
      st  = 1;
      ex  = 1'b0;
      val = n - j / T;
    end else begin
      st  = 2;
      ex  = (j == n * T);
      val = 0;
    end
`endif
  endtask

  task automatic run_check(string nm, int n, int jmax);
    int v;
    int s;
    bit x;
    sw = 1'b0;
    for (int j = 0; j <= jmax; j++) begin
      run_model(n, j, v, s, x);
      push(nm, v, s, x);
      tick();
      compare();
    end
  endtask

  initial begin
    int v;

    // reset state
    push("reset", 0, 0, 0);
    do_reset();
    compare();

    // held key yields a single increment after D+1 edges
    key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      push("held_key", (i >= D + 1) ? 1 : 0, 0, 0);
      tick();
      compare();
    end
    key_n = 1'b1;
    tick();

    // table: 31 presses walk 01..30 then wrap to 00
    do_reset();
    v = 0;
    for (int i = 0; i < 31; i++) begin
      v = (v == 30) ? 0 : v + 1;
      tbl.push_back('{1'b1, 1'b1, 0, v, 0, 1'b0});
    end
    foreach (tbl[i]) begin
      push($sformatf("press_%0d", i + 1), tbl[i].val, tbl[i].st, tbl[i].ex);
      sw = tbl[i].sw;
      if (tbl[i].is_press) press();
      else repeat (tbl[i].edges) tick();
      compare();
    end

    // preset 12 full countdown
    do_reset();
    set_preset(12);
    run_check("run12", 12, 125);

    // preset 05 aborted after 23 cycles
    do_reset();
    set_preset(5);
    run_check("run05", 5, 22);
    sw = 1'b1;
    push("abort05", 5, 0, 0);
    tick();
    compare();

    // preset 00 goes straight to DONE
    do_reset();
    sw = 1'b0;
    push("zero_done", 0, 2, 1);
    tick();
    compare();
    push("zero_hold", 0, 2, 0);
    tick();
    compare();
    push("done_key", 0, 2, 0);
    press();
    compare();
    sw = 1'b1;
    push("done_to_set", 0, 0, 0);
    tick();
    compare();

    // reset during RUN at count 07
    do_reset();
    set_preset(8);
    run_check("run08", 8, 15);
    reset = 1'b1;
    push("mid_reset", 0, 0, 0);
    tick();
    compare();
    sw = 1'b1;
    tick();
    reset = 1'b0;

    // preset 02: done at 20 or periodic reload
    do_reset();
    set_preset(2);
    run_check("run02", 2, 45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ticket_timer_ctrl.md
# ticket_timer_ctrl

Sequencer for the ticket-window countdown: owns the two-digit BCD preset/countdown, the debounced increment key and the 1 Hz tick, and steps through set → run → done. Sits between the raw board inputs (key, mode switch) and the 7-segment display encoders. Emits BCD digits and status only; segment encoding stays downstream.

## Interface
- `TICK_CYC`, default 12_000_000: clock cycles per countdown step (1 s at 12 MHz).
- `DEBOUNCE_CYC`, default 500_000: consecutive low cycles that qualify a key press.
- `MAX_TENS`, default 3: preset upper limit is `MAX_TENS`·10 + 0, i.e. 30 by default.
- `clk` input, 1 bit: single clock; all logic runs on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `key_n` input, 1 bit: raw increment button, active-low, not debounced.
- `sw` input, 1 bit: mode switch; 1 = set mode, 0 = run.
- `tens` output, 4 bits: BCD tens digit shown.
- `ones` output, 4 bits: BCD ones digit shown.
- `state` output, 2 bits: 0 = SET, 1 = RUN, 2 = DONE.
- `expired` output, 1 bit: one-cycle pulse on countdown completion.
- `busy` output, 1 bit: high while `state` is RUN.

## Operation
- Reset state: SET, preset = 00, count = 00, prescaler = 0, debounce counter = 0. All outputs are 0.
- Debounce:
  - The counter increments while `key_n` = 0, clears when `key_n` = 1, and saturates at `DEBOUNCE_CYC`.
  - A press event fires in the single cycle the counter reaches `DEBOUNCE_CYC`.
  - A held key yields exactly one event.
- SET:
  - `tens`/`ones` show the preset.
  - Each press event adds 1 in BCD (09 → 10).
  - At `MAX_TENS`·10 a press wraps the preset to 00.
  - Ones never exceeds 9. Tens never exceeds `MAX_TENS`.
  - Exit: `sw` = 0 → RUN, load count = preset, clear prescaler.
  - If preset = 00, go to DONE instead and pulse `expired`.
- RUN:
  - Key events are ignored; the debouncer keeps running.
  - The prescaler counts 0..`TICK_CYC`−1.
  - In the cycle it equals `TICK_CYC`−1, count decrements in BCD (10 → 09) and the prescaler wraps to 0.
  - If the decrement takes count 01 → 00, go to DONE.
  - `sw` = 1 → SET immediately. Count is discarded and the preset is retained.
- DONE:
  - Shows 00; `busy` = 0.
  - `sw` = 1 → SET with the preset retained. Key events are ignored.
- Simultaneous events:
  - A tick and `sw` = 1 in the same cycle: `sw` wins (→ SET, no decrement).
  - A press event and `sw` = 0 in SET: the transition wins and the press is dropped.
- Mid-run reset returns to the reset state in the next cycle, regardless of `sw`.

## Timing
- `sw` is sampled each cycle. Transitions take effect on the next edge; `state`, `busy`, `tens` and `ones` update together.
- Preset N ≥ 1: `expired` is high for exactly one cycle, N·`TICK_CYC` cycles after the first RUN cycle, in the same cycle `state` first reads DONE.
- Press-to-display latency: the preset increments on the edge after the event cycle, i.e. `DEBOUNCE_CYC`+1 edges after `key_n` first samples low.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `TICKET_AUTO_RELOAD_EN`
  - Defined: on the 01 → 00 step, count reloads the preset and the block stays in RUN; `expired` still pulses one cycle per period. DONE is reachable only via preset 00.
  - Undefined: behaviour exactly as in Operation.

## Structure
- Package `ticket_pkg`:
  - state enum (SET/RUN/DONE, 2 bits);
  - BCD digit typedef (4 bits);
  - two-digit BCD struct;
  - BCD increment/decrement functions.
- Sub-module `key_debounce`:
  - params `DEBOUNCE_CYC`; ports `clk`, `reset`, `key_n`, `press`;
  - one instance.
- Prescaler, BCD registers and FSM stay in the top.

## Test plan
Use `TICK_CYC` = 10 and `DEBOUNCE_CYC` = 4 in the bench.
- Reset, then hold `key_n` low for 20 cycles → preset 01 only, `state` = 0.
- Apply 31 clean presses in SET → preset reads 01, 02 … 09, 10 … 30, then 00.
- Preset 12, `sw` 1 → 0 → `busy` = 1; digits step 12, 11, 10, 09 … every 10 cycles; `expired` pulses once at cycle 120; `state` = 2, digits 00.
- Preset 05, `sw` = 0 for 23 cycles, then `sw` = 1 → `state` = 0, digits 05; no `expired` pulse.
- Preset 00, `sw` = 0 → DONE next edge with one `expired` pulse; key presses in DONE leave preset at 00.
- Assert `reset` mid-RUN at count 07 → all outputs 0 and `state` = 0 next edge. With `TICKET_AUTO_RELOAD_EN`, preset 02 gives `expired` every 20 cycles and `state` stays 1.
